// File: rtl/parallel_fir_core.sv
// L-way block-parallel FIR: L samples in and L filtered samples out per clock, two-stage
// pipeline (products, then per-lane sums), with shadow/active coefficient banks and atomic commit.
module parallel_fir_core #(
    parameter int L      = 2,
    parameter int TAPS   = 16,
    parameter int DATA_W = 32,
    parameter int COEF_W = 32,
    parameter int ACC_W  = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [L*DATA_W-1:0]       x_in,
    input  logic                      coef_we,
    input  logic [$clog2(TAPS)-1:0]   coef_addr,
    input  logic signed [COEF_W-1:0]  coef_data,
    input  logic                      coef_commit,
    output logic                      out_valid,
    output logic [L*ACC_W-1:0]        y_out
);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int WIN_N  = TAPS - 1 + L;

    // Full-precision product folded into the accumulator width (sign-extend or wrap).
    function automatic logic signed [ACC_W-1:0] wrap_acc(input logic signed [PROD_W-1:0] p);
        return ACC_W'(p);
    endfunction

    logic signed [DATA_W-1:0] r_hist        [TAPS-1];
    logic signed [COEF_W-1:0] r_coef_sh     [TAPS];
    logic signed [COEF_W-1:0] r_coef_act    [TAPS];
    logic signed [COEF_W-1:0] w_coef_sh_nxt [TAPS];
    logic signed [DATA_W-1:0] w_win         [WIN_N];
    logic signed [ACC_W-1:0]  w_prod        [L][TAPS];
    logic signed [ACC_W-1:0]  r_prod_p1     [L][TAPS];
    logic signed [ACC_W-1:0]  w_sum         [L];
    logic signed [ACC_W-1:0]  r_sum_p2      [L];
    logic                     r_vld_p1;
    logic                     r_vld_p2;

    // A write and a commit in the same cycle commit the bank including that write.
    always_comb begin
        w_coef_sh_nxt = r_coef_sh;
        if (coef_we && (int'(coef_addr) < TAPS))
            w_coef_sh_nxt[coef_addr] = coef_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < TAPS; k++) begin
                r_coef_sh[k]  <= (k == 0) ? COEF_W'(1) : '0;
                r_coef_act[k] <= (k == 0) ? COEF_W'(1) : '0;
            end
        end else begin
            r_coef_sh <= w_coef_sh_nxt;
            if (coef_commit)
                r_coef_act <= w_coef_sh_nxt;
        end
    end

    // Window ordered oldest first: history, then lanes 0..L-1 of the current block.
    always_comb begin
        for (int i = 0; i < TAPS - 1; i++)
            w_win[i] = r_hist[i];
        for (int j = 0; j < L; j++)
            w_win[TAPS-1+j] = x_in[j*DATA_W +: DATA_W];
    end

    always_comb begin
        for (int j = 0; j < L; j++)
            for (int k = 0; k < TAPS; k++)
                w_prod[j][k] = wrap_acc(PROD_W'(w_win[TAPS-1+j-k]) * PROD_W'(r_coef_act[k]));
    end

    // ---- stage p1: history shift and product registers ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < TAPS - 1; i++)
                r_hist[i] <= '0;
            for (int j = 0; j < L; j++)
                for (int k = 0; k < TAPS; k++)
                    r_prod_p1[j][k] <= '0;
            r_vld_p1 <= 1'b0;
        end else begin
            if (in_valid) begin
                for (int i = 0; i < TAPS - 1; i++)
                    r_hist[i] <= w_win[i+L];
                r_prod_p1 <= w_prod;
            end
            r_vld_p1 <= in_valid;
        end
    end

    always_comb begin
        for (int j = 0; j < L; j++) begin
            w_sum[j] = '0;
            for (int k = 0; k < TAPS; k++)
                w_sum[j] = w_sum[j] + r_prod_p1[j][k];
        end
    end

    // ---- stage p2: per-lane sums, held while no new block arrives ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int j = 0; j < L; j++)
                r_sum_p2[j] <= '0;
            r_vld_p2 <= 1'b0;
        end else begin
            if (r_vld_p1)
                r_sum_p2 <= w_sum;
            r_vld_p2 <= r_vld_p1;
        end
    end

    always_comb begin
        y_out = '0;
        for (int j = 0; j < L; j++)
            y_out[j*ACC_W +: ACC_W] = r_sum_p2[j];
    end

    assign out_valid = r_vld_p2;

endmodule

// File: tb/tb_parallel_fir_core.sv
// Directed bench for parallel_fir_core (L=2, TAPS=4); a second instance at ACC_W=40 checks wrap.
module tb_parallel_fir_core;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic [63:0]  x_in = '0;
    logic         coef_we = 1'b0;
    logic [1:0]   coef_addr = '0;
    logic signed [15:0] coef_data = '0;
    logic         coef_commit = 1'b0;
    logic         ov_a, ov_b;
    logic [127:0] y_a;
    logic [79:0]  y_b;
    logic [63:0]  y0, y1;
    logic [39:0]  yb0, yb1;
    int           n_chk = 0;
    int           n_fail = 0;

    localparam logic [31:0] XMAX = 32'h7FFF_FFFF;
    localparam logic [63:0] HX3  = 64'd211099789983747;
    localparam logic [63:0] HX4  = 64'd281466386644996;
    localparam logic [63:0] HB4  = -64'sd8590065660;

    parallel_fir_core #(.L(2), .TAPS(4), .DATA_W(32), .COEF_W(16), .ACC_W(64)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .x_in(x_in),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .coef_commit(coef_commit), .out_valid(ov_a), .y_out(y_a)
    );

    parallel_fir_core #(.L(2), .TAPS(4), .DATA_W(32), .COEF_W(16), .ACC_W(40)) u_dut40 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .x_in(x_in),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .coef_commit(coef_commit), .out_valid(ov_b), .y_out(y_b)
    );

    assign y0  = y_a[63:0];
    assign y1  = y_a[127:64];
    assign yb0 = y_b[39:0];
    assign yb1 = y_b[79:40];

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic v, input logic [31:0] a, input logic [31:0] b);
        in_valid = v;
        x_in     = {b, a};
        step();
    endtask

    task automatic cyc(input string tag, input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic ev, input logic [63:0] e0, input logic [63:0] e1);
        drv(v, a, b);
        chk({tag, ".ov"}, 64'(ov_a), 64'(ev));
        chk({tag, ".y0"}, y0, e0);
        chk({tag, ".y1"}, y1, e1);
    endtask

    task automatic wr_coef(input logic [1:0] addr, input logic signed [15:0] data);
        coef_we   = 1'b1;
        coef_addr = addr;
        coef_data = data;
        step();
        coef_we   = 1'b0;
    endtask

    task automatic commit();
        coef_commit = 1'b1;
        step();
        coef_commit = 1'b0;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        x_in     = '0;
        rst      = 1'b0;
        step();
        rst      = 1'b1;
    endtask

    logic [63:0] exp0 [4] = '{64'd1, 64'd3, 64'd0, 64'd0};
    logic [63:0] exp1 [4] = '{64'd2, 64'd4, 64'd0, 64'd0};

    initial begin
        logic [63:0] p0, p1;
        #1 rst = 1'b0;
        step();
        step();
        chk("rst.ov", 64'(ov_a), 64'd0);
        chk("rst.y0", y0, 64'd0);
        chk("rst.y1", y1, 64'd0);
        rst = 1'b1;

        // identity coefficients after reset
        cyc("id0", 1'b1, 32'd1, 32'd2, 1'b0, 64'd0, 64'd0);
        cyc("id1", 1'b1, 32'd3, 32'd4, 1'b1, 64'd1, 64'd2);
        cyc("id2", 1'b0, 32'd0, 32'd0, 1'b1, 64'd3, 64'd4);
        cyc("id3", 1'b0, 32'd0, 32'd0, 1'b0, 64'd3, 64'd4);

        // impulse response with h = {1,2,3,4}
        do_reset();
        wr_coef(2'd0, 16'sd1);
        wr_coef(2'd1, 16'sd2);
        wr_coef(2'd2, 16'sd3);
        wr_coef(2'd3, 16'sd4);
        commit();
        cyc("imp_idle", 1'b0, 32'd0, 32'd0, 1'b0, 64'd0, 64'd0);
        cyc("imp0", 1'b1, 32'd1, 32'd0, 1'b0, 64'd0, 64'd0);
        cyc("imp1", 1'b1, 32'd0, 32'd0, 1'b1, 64'd1, 64'd2);
        cyc("imp2", 1'b1, 32'd0, 32'd0, 1'b1, 64'd3, 64'd4);
        cyc("imp3", 1'b1, 32'd0, 32'd0, 1'b1, 64'd0, 64'd0);
        cyc("imp4", 1'b0, 32'd0, 32'd0, 1'b1, 64'd0, 64'd0);
        cyc("imp5", 1'b0, 32'd0, 32'd0, 1'b0, 64'd0, 64'd0);

        // same impulse with three idle cycles after every block
        p0 = 64'd0;
        p1 = 64'd0;
        for (int b = 0; b < 4; b++) begin
            cyc($sformatf("gap%0d.blk", b), 1'b1, (b == 0) ? 32'd1 : 32'd0, 32'd0, 1'b0, p0, p1);
            cyc($sformatf("gap%0d.g1", b), 1'b0, 32'd0, 32'd0, 1'b1, exp0[b], exp1[b]);
            cyc($sformatf("gap%0d.g2", b), 1'b0, 32'd0, 32'd0, 1'b0, exp0[b], exp1[b]);
            cyc($sformatf("gap%0d.g3", b), 1'b0, 32'd0, 32'd0, 1'b0, exp0[b], exp1[b]);
            p0 = exp0[b];
            p1 = exp1[b];
        end

        // commit in the same cycle as a block: that block keeps the old bank
        do_reset();
        wr_coef(2'd0, 16'sd2);
        coef_commit = 1'b1;
        cyc("col0", 1'b1, 32'd5, 32'd6, 1'b0, 64'd0, 64'd0);
        coef_commit = 1'b0;
        cyc("col1", 1'b1, 32'd5, 32'd6, 1'b1, 64'd5, 64'd6);
        cyc("col2", 1'b0, 32'd0, 32'd0, 1'b1, 64'd10, 64'd12);
        // write and commit together, then a commit with nothing new
        coef_we = 1'b1; coef_addr = 2'd0; coef_data = 16'sd3; coef_commit = 1'b1;
        cyc("wc0", 1'b0, 32'd0, 32'd0, 1'b0, 64'd10, 64'd12);
        coef_we = 1'b0; coef_commit = 1'b0;
        cyc("wc1", 1'b1, 32'd1, 32'd1, 1'b0, 64'd10, 64'd12);
        cyc("wc2", 1'b0, 32'd0, 32'd0, 1'b1, 64'd3, 64'd3);
        coef_commit = 1'b1;
        cyc("nop0", 1'b1, 32'd1, 32'd2, 1'b0, 64'd3, 64'd3);
        coef_commit = 1'b0;
        cyc("nop1", 1'b0, 32'd0, 32'd0, 1'b1, 64'd3, 64'd6);

        // large operands: exact at 64 bits, wrapped at 40 bits
        do_reset();
        for (int k = 0; k < 4; k++)
            wr_coef(2'(k), 16'sd32767);
        commit();
        cyc("wr_idle", 1'b0, 32'd0, 32'd0, 1'b0, 64'd0, 64'd0);
        drv(1'b1, XMAX, XMAX);
        drv(1'b1, XMAX, XMAX);
        drv(1'b1, XMAX, XMAX);
        chk("wrap.b2.y0", y0, HX3);
        chk("wrap.b2.y1", y1, HX4);
        drv(1'b0, 32'd0, 32'd0);
        chk("wrap.ov", 64'(ov_a), 64'd1);
        chk("wrap.y0", y0, HX4);
        chk("wrap.y1", y1, HX4);
        chk("wrap40.ov", 64'(ov_b), 64'd1);
        chk("wrap40.y0", 64'($signed(yb0)), HB4);
        chk("wrap40.y1", 64'($signed(yb1)), HB4);

        // asynchronous reset in the middle of a ramp
        drv(1'b1, 32'd1, 32'd2);
        drv(1'b1, 32'd3, 32'd4);
        drv(1'b1, 32'd5, 32'd6);
        #3;
        rst = 1'b0;
        #1;
        chk("arst.ov", 64'(ov_a), 64'd0);
        chk("arst.y0", y0, 64'd0);
        chk("arst.y1", y1, 64'd0);
        chk("arst.ov40", 64'(ov_b), 64'd0);
        rst = 1'b1;
        cyc("post0", 1'b1, 32'd7, 32'd8, 1'b0, 64'd0, 64'd0);
        cyc("post1", 1'b1, 32'd9, 32'd10, 1'b1, 64'd7, 64'd8);
        cyc("post2", 1'b0, 32'd0, 32'd0, 1'b1, 64'd9, 64'd10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
